// File: rtl/pwl_synth_pkg.sv
// Shared definitions for the piecewise-linear synth blocks:
// register bus width and register field codes.
package pwl_synth_pkg;

  localparam int REG_BITS = 16;

  typedef enum logic [1:0] {
    FLD_PERIOD = 2'd0,
    FLD_TARGET = 2'd1,
    FLD_RATE   = 2'd2,
    FLD_CTRL   = 2'd3
  } field_e;

endpackage

// File: rtl/pwls_sweep_step.sv
// One sweep step: load target at rate 0, otherwise move
// the period one count toward target on gated frames.
module pwls_sweep_step #(
  parameter int BITS       = 12,
  parameter int SWEEP_BITS = 4
) (
  input  logic [BITS-1:0]       cur,
  input  logic [BITS-1:0]       tgt,
  input  logic [SWEEP_BITS-1:0] rate,
  input  logic [SWEEP_BITS-1:0] frame,
  output logic [BITS-1:0]       nxt
);

  logic [SWEEP_BITS-1:0] mask;
  logic                  gate;

  // Gate on the low 'rate' frame bits being zero, then step
  always_comb begin
    mask = '0;
    for (int i = 0; i < SWEEP_BITS; i++) begin
      mask[i] = int'(rate) > i;
    end
    gate = (frame & mask) == '0;
    nxt  = cur;
    if (rate == '0) begin
      nxt = tgt;
    end else if (gate && (cur < tgt)) begin
      nxt = cur + 1'b1;
    end else if (gate && (cur > tgt)) begin
      nxt = cur - 1'b1;
    end
  end

endmodule

// File: rtl/pwls_multichannel_sweep_osc.sv
// Time-multiplexed multi-channel oscillator with
// octave/mantissa period and per-channel period sweep.
module pwls_multichannel_sweep_osc
  import pwl_synth_pkg::*;
#(
  parameter int BITS         = 12,
  parameter int OCT_BITS     = 3,
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_BITS   = 20,
  parameter int SWEEP_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [5:0]          reg_waddr,
  input  logic [REG_BITS-1:0] reg_wdata,
  input  logic                reg_we,
  output logic                out_valid,
  output logic [((NUM_CHANNELS > 1) ?
                 $clog2(NUM_CHANNELS) : 1)-1:0] out_channel,
  output logic [BITS-1:0]     out_phase,
  output logic [BITS-1:0]     out_period,
  output logic                frame_tick
);

  localparam int CW = (NUM_CHANNELS > 1) ?
                      $clog2(NUM_CHANNELS) : 1;
  localparam int MW = BITS - OCT_BITS;

  logic [BITS-1:0]       period_q [NUM_CHANNELS];
  logic [BITS-1:0]       target_q [NUM_CHANNELS];
  logic [SWEEP_BITS-1:0] rate_q   [NUM_CHANNELS];
  logic                  ena_q    [NUM_CHANNELS];
  logic                  prst_q   [NUM_CHANNELS];
  logic [PHASE_BITS-1:0] phase_q  [NUM_CHANNELS];

  logic [CW-1:0]         slot_q;
  logic [SWEEP_BITS-1:0] frame_q;

  logic [BITS-1:0]       cur_period;
  logic [BITS-1:0]       swept;
  logic [PHASE_BITS-1:0] inc;
  logic [PHASE_BITS-1:0] phase_nxt;
  logic                  last_slot;
  logic                  slot_live;

  logic [3:0]            wr_ch;
  logic [CW-1:0]         wr_idx;
  logic                  wr_ok;
  field_e                wr_fld;

  assign cur_period = period_q[slot_q];
  assign inc = PHASE_BITS'({1'b1, cur_period[MW-1:0]})
               << cur_period[BITS-1:MW];
  assign phase_nxt = prst_q[slot_q] ? '0
                   : phase_q[slot_q] + inc;
  assign last_slot = slot_q == CW'(NUM_CHANNELS - 1);
  assign slot_live = en && ena_q[slot_q];

  assign wr_ch  = reg_waddr[5:2];
  assign wr_idx = wr_ch[CW-1:0];
  assign wr_ok  = reg_we && (int'(wr_ch) < NUM_CHANNELS);
  assign wr_fld = field_e'(reg_waddr[1:0]);

  pwls_sweep_step #(
    .BITS       (BITS),
    .SWEEP_BITS (SWEEP_BITS)
  ) u_step (
    .cur   (cur_period),
    .tgt   (target_q[slot_q]),
    .rate  (rate_q[slot_q]),
    .frame (frame_q),
    .nxt   (swept)
  );

  // Per-channel state: slot update first, register write last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        period_q[c] <= '0;
        target_q[c] <= '0;
        rate_q[c]   <= '0;
        ena_q[c]    <= 1'b0;
        prst_q[c]   <= 1'b0;
        phase_q[c]  <= '0;
      end
    end else begin
      if (en) begin
        if (prst_q[slot_q] || ena_q[slot_q]) begin
          phase_q[slot_q] <= phase_nxt;
        end
        prst_q[slot_q] <= 1'b0;
        if (ena_q[slot_q]) begin
          period_q[slot_q] <= swept;
        end
      end
      if (wr_ok) begin
        unique case (wr_fld)
          FLD_PERIOD: begin
            period_q[wr_idx] <= reg_wdata[BITS-1:0];
            target_q[wr_idx] <= reg_wdata[BITS-1:0];
          end
          FLD_TARGET: target_q[wr_idx] <= reg_wdata[BITS-1:0];
          FLD_RATE:   rate_q[wr_idx] <= reg_wdata[SWEEP_BITS-1:0];
          FLD_CTRL: begin
            ena_q[wr_idx]  <= reg_wdata[0];
            prst_q[wr_idx] <= reg_wdata[1];
          end
        endcase
      end
    end
  end

  // Slot and frame counters advance only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      frame_q <= '0;
    end else if (en) begin
      slot_q <= last_slot ? '0 : slot_q + 1'b1;
      if (last_slot) begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  // Output registers; data holds unless a live slot ran
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      frame_tick  <= 1'b0;
      out_channel <= '0;
      out_phase   <= '0;
      out_period  <= '0;
    end else begin
      out_valid  <= slot_live;
      frame_tick <= en && last_slot;
      if (slot_live) begin
        out_channel <= slot_q;
        out_phase   <= phase_nxt[PHASE_BITS-1 -: BITS];
        out_period  <= swept;
      end
    end
  end

endmodule

// File: tb/tb_pwls_multichannel_sweep_osc.sv
// Bench: directed vector table, sweep sequence, async reset,
// and random traffic against an arithmetic reference model.
module tb_pwls_multichannel_sweep_osc;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [5:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        out_valid;
  logic [1:0]  out_channel;
  logic [11:0] out_phase;
  logic [11:0] out_period;
  logic        frame_tick;

  pwls_multichannel_sweep_osc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .out_phase   (out_phase),
    .out_period  (out_period),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        en;
    logic        we;
    logic [5:0]  a;
    logic [15:0] d;
    int          v;
    int          t;
    int          ch;
    int          ph;
    int          pr;
  } vec_t;

  vec_t tbl[26];

  // reference model state
  int m_per[4], m_tgt[4], m_rate[4];
  int m_ena[4], m_prst[4], m_ph[4];
  int m_slot, m_fc;
  int ev, et, ech, eph, epr;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic w,
                              input int a, input int d,
                              input int v, input int t,
                              input int ch, input int ph,
                              input int pr);
    vec_t r;
    r.en = e; r.we = w; r.a = 6'(a); r.d = 16'(d);
    r.v = v; r.t = t; r.ch = ch; r.ph = ph; r.pr = pr;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_per[c] = 0; m_tgt[c] = 0; m_rate[c] = 0;
      m_ena[c] = 0; m_prst[c] = 0; m_ph[c] = 0;
    end
    m_slot = 0; m_fc = 0;
    ev = 0; et = 0; ech = 0; eph = 0; epr = 0;
  endtask

  task automatic model_step(input bit e, input bit w,
                            input int a, input int d);
    int c, cur, np, inc, ch;
    ev = 0; et = 0;
    if (e) begin
      c = m_slot;
      cur = m_per[c];
      np = cur;
      if (m_rate[c] == 0) begin
        np = m_tgt[c];
      end else if (((m_fc % 16) % (1 << m_rate[c])) == 0) begin
        if (cur < m_tgt[c]) np = cur + 1;
        else if (cur > m_tgt[c]) np = cur - 1;
      end
      inc = (512 + cur % 512) * (1 << (cur / 512));
      if (m_prst[c] != 0) m_ph[c] = 0;
      else if (m_ena[c] != 0) m_ph[c] = (m_ph[c] + inc) % (1 << 20);
      m_prst[c] = 0;
      if (m_ena[c] != 0) begin
        m_per[c] = np;
        ev = 1; ech = c; eph = m_ph[c] / 256; epr = np;
      end
      et = (c == 3) ? 1 : 0;
      m_slot = (c + 1) % 4;
      if (c == 3) m_fc++;
    end
    if (w && (a / 4) < 4) begin
      ch = a / 4;
      case (a % 4)
        0: begin m_per[ch] = d % 4096; m_tgt[ch] = d % 4096; end
        1: m_tgt[ch] = d % 4096;
        2: m_rate[ch] = d % 16;
        default: begin
          m_ena[ch] = d % 2;
          m_prst[ch] = (d / 2) % 2;
        end
      endcase
    end
  endtask

  task automatic check_outs(input string tag, input int v,
                            input int t, input int ch,
                            input int ph, input int pr);
    chk({tag, ".valid"}, int'(out_valid), v);
    chk({tag, ".tick"}, int'(frame_tick), t);
    chk({tag, ".chan"}, int'(out_channel), ch);
    chk({tag, ".phase"}, int'(out_phase), ph);
    chk({tag, ".period"}, int'(out_period), pr);
  endtask

  // one clock of stimulus, model-checked
  task automatic cyc(input bit e, input bit w,
                     input int a, input int d);
    en = e; reg_we = w;
    reg_waddr = 6'(a); reg_wdata = 16'(d);
    @(posedge clk);
    model_step(e, w, a, d);
    #1;
    check_outs("model", ev, et, ech, eph, epr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; reg_we = 1'b0;
    reg_waddr = '0; reg_wdata = '0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  int k;
  int ch, fld, a, d;

  initial begin
    tbl[0]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 'h000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 8, 'h300, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 9, 'h200, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 10, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 11, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0, 2, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 2, 0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 0, 2, 6, 'h200);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 2, 6, 'h200);
    tbl[10] = mk(1, 0, 0, 0, 1, 0, 0, 4, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 4, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 0, 2, 10, 'h200);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 2, 10, 'h200);
    tbl[14] = mk(1, 1, 0, 'h200, 1, 0, 0, 6, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 6, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 0, 2, 14, 'h200);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 2, 14, 'h200);
    tbl[18] = mk(1, 0, 0, 0, 1, 0, 0, 10, 'h200);
    tbl[19] = mk(0, 1, 11, 3, 0, 0, 0, 10, 'h200);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 10, 'h200);
    tbl[21] = mk(1, 0, 0, 0, 1, 0, 2, 0, 'h200);
    tbl[22] = mk(1, 0, 0, 0, 0, 1, 2, 0, 'h200);
    tbl[23] = mk(1, 0, 0, 0, 1, 0, 0, 14, 'h200);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 14, 'h200);
    tbl[25] = mk(1, 0, 0, 0, 1, 0, 2, 4, 'h200);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      en = tbl[i].en; reg_we = tbl[i].we;
      reg_waddr = tbl[i].a; reg_wdata = tbl[i].d;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].t,
                 tbl[i].ch, tbl[i].ph, tbl[i].pr);
    end

    // ch1 upward sweep at rate 2, then en-low freeze
    do_reset();
    cyc(0, 1, 4, 'h100);
    cyc(0, 1, 5, 'h104);
    cyc(0, 1, 6, 2);
    cyc(0, 1, 7, 1);
    k = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1, 0, 0, 0);
      if (out_valid && out_channel == 2'd1) begin
        chk($sformatf("sweep_f%0d", k), int'(out_period),
            'h100 + ((k / 4 + 1 > 4) ? 4 : k / 4 + 1));
        k++;
      end
    end
    chk("sweep_frames", k, 20);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

    // random traffic with an asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) cyc(1, 0, 0, 0);
      end
      if (i >= 700 && i < 710) begin
        cyc(0, 0, 0, 0);
      end else begin
        ch  = ($urandom % 8 == 0) ? 4 + int'($urandom % 12)
                                  : int'($urandom % 4);
        fld = int'($urandom % 4);
        a   = ch * 4 + fld;
        d   = int'($urandom % 65536);
        cyc(($urandom % 10) != 0, ($urandom % 4) == 0, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
